// File: rtl/fetch_queue_pkg.sv
// Shared widths, reset PC, PC increment and FSM encodings for the fetch queue.
package fetch_queue_pkg;

  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W      = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_INC           = 4;

  typedef enum logic {
    FQ_RUN   = 1'b0,
    FQ_REDIR = 1'b1
  } fq_state_e;

endpackage

// File: rtl/fq_ram.sv
// DEPTH-entry register array for (pc, inst) pairs: one write port, one async read port.
module fq_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: prefetch queue between the ROM and ID with delay-slot branch redirect.
// Optional FETCH_QUEUE_PERF_EN adds saturating flush / empty-cycle counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS_W,
  parameter int                INST_W   = INST_BUS_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     branch_flag_i,
  input  logic [ADDR_W-1:0]        branch_target_address_i,
  input  logic [INST_W-1:0]        rom_data_i,
  output logic [ADDR_W-1:0]        rom_addr_o,
  output logic                     rom_ce_o,
  output logic [ADDR_W-1:0]        id_pc_o,
  output logic [INST_W-1:0]        id_inst_o,
  output logic                     id_valid_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]              perf_flush_o,
  output logic [31:0]              perf_empty_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + INST_W;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] redir_tgt_q, redir_tgt_d;
  fq_state_e         state_q, state_d;

  logic [ENT_W-1:0]  head_ent;
  logic [ADDR_W-1:0] head_pc, delay_pc;
  logic [INST_W-1:0] head_inst;
  logic              valid, pop, push, issue;
  logic [CNT_W:0]    occ_next;
  logic              br_take, br_queued, br_inflight, br_unissued, kill_issue;

  fq_ram #(.DEPTH(DEPTH), .W(ENT_W)) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({inflight_pc_q, rom_data_i}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_ent)
  );

  assign head_pc   = head_ent[ENT_W-1:INST_W];
  assign head_inst = head_ent[INST_W-1:0];
  assign delay_pc  = head_pc + PC_STEP;

  assign valid    = (count_q != '0);
  assign pop      = valid && !stall_i;
  assign occ_next = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
  assign issue    = !rst && (occ_next < (CNT_W+1)'(DEPTH));

  // The delay slot (head+4) is the next entry in sequence: queue, then in-flight, then unissued.
  assign br_take     = branch_flag_i && pop;
  assign br_queued   = br_take && (count_q >= CNT_W'(2));
  assign br_inflight = br_take && (count_q == CNT_W'(1)) && inflight_q;
  assign br_unissued = br_take && (count_q == CNT_W'(1)) && !inflight_q;

  // A same-cycle issue is wrong-path unless it is itself fetching the delay slot.
  assign kill_issue = br_queued || br_inflight || (br_unissued && (fetch_pc_q != delay_pc));
  assign push       = inflight_q && !br_queued;

  always_comb begin
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    inflight_d    = issue && !kill_issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
    fetch_pc_d    = issue ? fetch_pc_q + PC_STEP : fetch_pc_q;
    redir_tgt_d   = redir_tgt_q;
    state_d       = state_q;

    if (state_q == FQ_REDIR && issue) begin
      fetch_pc_d = redir_tgt_q;
      state_d    = FQ_RUN;
    end

    if (br_queued) begin
      wr_ptr_d   = rd_ptr_q + PTR_W'(1) + PTR_W'(1);
      count_d    = CNT_W'(1);
      fetch_pc_d = branch_target_address_i;
    end else if (br_inflight) begin
      fetch_pc_d = branch_target_address_i;
    end else if (br_unissued) begin
      if (issue && (fetch_pc_q == delay_pc)) begin
        fetch_pc_d = branch_target_address_i;
      end else begin
        fetch_pc_d  = delay_pc;
        redir_tgt_d = branch_target_address_i;
        state_d     = FQ_REDIR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fetch_pc_q    <= RESET_PC;
      redir_tgt_q   <= '0;
      state_q       <= FQ_RUN;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_pc_q    <= fetch_pc_d;
      redir_tgt_q   <= redir_tgt_d;
      state_q       <= state_d;
    end
  end

  assign rom_ce_o   = issue;
  assign rom_addr_o = fetch_pc_q;
  assign id_valid_o = valid;
  assign id_pc_o    = valid ? head_pc : '0;
  assign id_inst_o  = valid ? head_inst : '0;
  assign count_o    = count_q;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]    perf_flush_q, perf_empty_q;
  logic [CNT_W:0] flush_n;
  logic [32:0]    flush_sum;

  always_comb begin
    flush_n = '0;
    if (br_queued) begin
      flush_n = {1'b0, count_q} - (CNT_W+1)'(2) + (CNT_W+1)'(inflight_q);
    end
    if (issue && kill_issue) begin
      flush_n = flush_n + (CNT_W+1)'(1);
    end
  end

  assign flush_sum = {1'b0, perf_flush_q} + 33'(flush_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_flush_q <= '0;
      perf_empty_q <= '0;
    end else begin
      perf_flush_q <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
      if (!valid && (perf_empty_q != 32'hFFFF_FFFF)) begin
        perf_empty_q <= perf_empty_q + 32'd1;
      end
    end
  end

  assign perf_flush_o = perf_flush_q;
  assign perf_empty_o = perf_empty_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue with a one-cycle-latency ROM model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = '0;
  logic [31:0] rom_data_i = '0;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic [2:0]  count_o;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_flush_o;
  logic [31:0] perf_empty_o;
`endif

  int checks   = 0;
  int failures = 0;
  int cur_row  = 0;

  fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (stall_i),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .rom_data_i              (rom_data_i),
    .rom_addr_o              (rom_addr_o),
    .rom_ce_o                (rom_ce_o),
    .id_pc_o                 (id_pc_o),
    .id_inst_o               (id_inst_o),
    .id_valid_o              (id_valid_o),
    .count_o                 (count_o)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_flush_o            (perf_flush_o),
    .perf_empty_o            (perf_empty_o)
`endif
  );

  // clock / ROM
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_model(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  always @(posedge clk) begin
    if (rom_ce_o) rom_data_i <= rom_model(rom_addr_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        chk;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_ce;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h expected=%0h", name, cur_row, act, exp);
    end
  endtask

  task automatic rrow(input logic chk);
    vec_t v;
    v = '{rst: 1'b1, stall: 1'b0, br: 1'b0, tgt: '0, chk: chk, e_valid: 1'b0,
          e_pc: '0, e_cnt: '0, e_ce: 1'b0, e_addr: '0};
    vecs.push_back(v);
  endtask

  task automatic row(input logic s, input logic b, input logic [31:0] t, input logic ev,
                     input logic [31:0] ep, input logic [2:0] en, input logic ece,
                     input logic [31:0] ea);
    vec_t v;
    v = '{rst: 1'b0, stall: s, br: b, tgt: t, chk: 1'b1, e_valid: ev,
          e_pc: ep, e_cnt: en, e_ce: ece, e_addr: ea};
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input logic ev, input logic [31:0] ep, input logic [2:0] en,
                               input logic ece, input logic [31:0] ea);
    check("id_valid", 64'(id_valid_o), 64'(ev));
    check("count", 64'(count_o), 64'(en));
    check("id_pc", 64'(id_pc_o), 64'(ep));
    check("id_inst", 64'(id_inst_o), 64'(ev ? rom_model(ep) : 32'h0));
    check("rom_ce", 64'(rom_ce_o), 64'(ece));
    if (ece) check("rom_addr", 64'(rom_addr_o), 64'(ea));
  endtask

  initial begin
    // reset release and streaming
    rrow(1'b0); rrow(1'b1);
    row(0,0,0, 0,32'h00,0, 1,32'h00);
    row(0,0,0, 0,32'h00,0, 1,32'h04);
    row(0,0,0, 1,32'h00,1, 1,32'h08);
    row(0,0,0, 1,32'h04,1, 1,32'h0C);
    // six-cycle stall from head 0x8
    row(1,0,0, 1,32'h08,1, 1,32'h10);
    row(1,0,0, 1,32'h08,2, 1,32'h14);
    row(1,0,0, 1,32'h08,3, 0,32'h00);
    row(1,0,0, 1,32'h08,4, 0,32'h00);
    row(1,0,0, 1,32'h08,4, 0,32'h00);
    row(1,0,0, 1,32'h08,4, 0,32'h00);
    row(0,0,0, 1,32'h08,4, 1,32'h18);
    row(0,0,0, 1,32'h0C,3, 1,32'h1C);
    row(0,0,0, 1,32'h10,3, 1,32'h20);
    row(0,0,0, 1,32'h14,3, 1,32'h24);
    row(0,0,0, 1,32'h18,3, 1,32'h28);
    row(0,0,0, 1,32'h1C,3, 1,32'h2C);
    // branch at 0x20 with delay slot queued
    row(1,0,0, 1,32'h20,3, 0,32'h00);
    row(0,1,32'h100, 1,32'h20,4, 1,32'h30);
    row(0,0,0, 1,32'h24,1, 1,32'h100);
    row(0,0,0, 0,32'h00,0, 1,32'h104);
    // branch at 0x100 with delay slot in flight
    row(0,1,32'h200, 1,32'h100,1, 1,32'h108);
    row(0,0,0, 1,32'h104,1, 1,32'h200);
    row(0,0,0, 0,32'h000,0, 1,32'h204);
    row(0,0,0, 1,32'h200,1, 1,32'h208);
    row(0,0,0, 1,32'h204,1, 1,32'h20C);
    // branch while stalled is ignored
    row(1,1,32'h300, 1,32'h208,1, 1,32'h210);
    row(0,0,0, 1,32'h208,2, 1,32'h214);
    row(0,0,0, 1,32'h20C,2, 1,32'h218);
    // mid-flow reset, then REDIR scenario
    rrow(1'b0); rrow(1'b1);
    row(0,0,0, 0,32'h00,0, 1,32'h00);
    row(0,0,0, 0,32'h00,0, 1,32'h04);
    row(0,0,0, 1,32'h00,1, 1,32'h08);
    row(0,0,0, 1,32'h04,1, 1,32'h0C);
    row(0,0,0, 1,32'h08,1, 1,32'h10);
    row(0,0,0, 1,32'h0C,1, 1,32'h14);
    row(0,0,0, 1,32'h10,1, 1,32'h18);
    row(0,0,0, 1,32'h14,1, 1,32'h1C);
    row(0,0,0, 1,32'h18,1, 1,32'h20);
    row(1,0,0, 1,32'h1C,1, 1,32'h24);
    row(1,0,0, 1,32'h1C,2, 1,32'h28);
    row(1,0,0, 1,32'h1C,3, 0,32'h00);
    row(0,1,32'h200, 1,32'h1C,4, 1,32'h2C);
    row(0,1,32'h100, 1,32'h20,1, 1,32'h200);
    row(0,0,0, 0,32'h00,0, 1,32'h24);
    row(0,0,0, 0,32'h00,0, 1,32'h100);
    row(0,0,0, 1,32'h24,1, 1,32'h104);
    row(0,0,0, 1,32'h100,1, 1,32'h108);
    row(0,0,0, 1,32'h104,1, 1,32'h10C);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      cur_row                 = i;
      rst                     = vecs[i].rst;
      stall_i                 = vecs[i].stall;
      branch_flag_i           = vecs[i].br;
      branch_target_address_i = vecs[i].tgt;
      #1;
      if (vecs[i].chk)
        check_outputs(vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_ce, vecs[i].e_addr);
    end

    // reset with a fetch in flight, then branch while empty is ignored
    cur_row = 1000;
    @(negedge clk);
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(id_valid_o), 64'd0);
    begin
      int n;
      n = 0;
      while (!rom_ce_o && n < 5) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("first_issue_seen", 64'(rom_ce_o), 64'd1);
      check("first_issue_cycle", 64'(n), 64'd0);
      check("first_issue_addr", 64'(rom_addr_o), 64'h0);
    end
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h500;
    @(negedge clk);
    #1;
    check("empty_br_valid", 64'(id_valid_o), 64'd0);
    @(negedge clk);
    branch_flag_i = 1'b0;
    #1;
    check_outputs(1'b1, 32'h0, 3'd1, 1'b1, 32'h08);
    @(negedge clk);
    #1;
    check_outputs(1'b1, 32'h4, 3'd1, 1'b1, 32'h0C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the fixed pc_reg + if_id pair.
- Sits between the synchronous instruction ROM and the ID stage.
- Prefetches sequential instructions into a DEPTH-entry (pc, inst) queue, presents the head to ID and absorbs stalls without refetching.
- Handles ID-resolved branches with one delay slot by discarding wrong-path entries and redirecting fetch.

Parameters:
- ADDR_W, 32, width of PC / ROM address.
- INST_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stall_i  in  1  ID cannot accept (ctrl stall[1]).
- branch_flag_i  in  1  head instruction is a taken branch/jump.
- branch_target_address_i  in  ADDR_W  redirect target.
- rom_data_i  in  INST_W  ROM read data, valid the cycle after the address.
- rom_addr_o  out  ADDR_W  ROM address.
- rom_ce_o  out  1  ROM enable; a request is issued when high.
- id_pc_o  out  ADDR_W  head PC.
- id_inst_o  out  INST_W  head instruction; 0 when empty.
- id_valid_o  out  1  queue non-empty.
- count_o  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (synchronous, active-high; the block uses one clock, clk, and the synchronous active-high reset rst):
  - rom_ce_o=0, fetch_pc=RESET_PC, queue empty, inflight=0, state=RUN.
  - Outputs: id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0.
  - rom_ce_o rises the first cycle after rst deasserts.
  - Reset mid-operation drops all entries, the in-flight response and any pending redirect.
- ROM latency is one cycle. Request at cycle t with address A; rom_data_i at t+1 is pushed as (A, data) if the request is not squashed.
- Issue rule: rom_ce_o=1 iff count + inflight − pop < DEPTH. On issue, rom_addr_o=fetch_pc and fetch_pc += 4, wrapping modulo 2^ADDR_W.
- Pop: occurs when id_valid_o && !stall_i. id_* show the head combinationally and hold while stalled.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - Full plus pop allows an issue that cycle.
  - Empty plus arriving data: the head appears next cycle. There is no bypass, so ID sees a minimum of 2 cycles from issue.
- Branch is honoured only when it coincides with a pop. The sequence after the head is head+4, head+8, … across queue then in-flight. The delay slot is head+4.
  - Delay slot already queued: keep it, discard the rest of the queue, squash any in-flight response, set fetch_pc=target.
  - Delay slot in flight: keep that response, discard nothing else, set fetch_pc=target.
  - Delay slot not yet issued: fetch_pc stays head+4. Latch the target and enter REDIR. In REDIR the next issue fetches head+4, then fetch_pc=target and return to RUN.
  - branch_flag_i with no pop (stalled or empty) is ignored.
- States: RUN, REDIR. REDIR is left only by issuing the delay-slot fetch or by reset.
- count_o is always equal to the number of valid entries. Pointers are log2(DEPTH) bits and wrap naturally.

Optional Feature:
- FETCH_QUEUE_PERF_EN defined: adds outputs perf_flush_o (32 bits, cumulative discarded and squashed entries) and perf_empty_o (32 bits, cycles with id_valid_o=0 after reset).
  - Both saturate at all-ones and are cleared by rst.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared defines: InstAddrBus/InstBus widths, RESET_PC default, PC increment constant 4, state encodings RUN/REDIR.
- Sub-module fq_ram: DEPTH×(ADDR_W+INST_W) register array with one write port and one async read port.
- Top holds pointers, inflight/squash flags, fetch_pc and the FSM.

Test Plan:
- Reset release, no stall, DEPTH=4: issues 0,4,8,12 on consecutive cycles; id_pc_o=0 at cycle 2; then one pop per cycle in PC order.
- stall_i high 6 cycles from head pc=8: queue fills to count_o=4, rom_ce_o=0, id_pc_o holds 8. Release gives 8,C,10,14 with no gaps.
- Branch at head pc=0x20 (queued 0x24, 0x28, 0x2C), target 0x100: next heads are 0x24 then 0x100; 0x28 and 0x2C are never presented.
- Branch at pc=0x20 with only 0x24 in flight: 0x24 is kept, then 0x100, 0x104.
- Queue holds only head 0x20, nothing in flight, branch: FSM enters REDIR; issues 0x24 then 0x100. Also: branch_flag_i while stalled has no effect.
- rst asserted mid-fill with an in-flight fetch: next cycle count_o=0, id_valid_o=0, and the first issue after release is RESET_PC.
